// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and shared constants for the stopwatch controller
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_PAUSED   = 2'd2,
      ST_LAP_HOLD = 2'd3
   } state_t;

   localparam int DEF_TICK_DIV = 100000;

   // The prescaler advances and ticks are issued only in these two states
   function automatic logic is_counting(input state_t s);
      return (s == ST_RUN) || (s == ST_LAP_HOLD);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_pulse.sv
// rtl/stopwatch_ctrl_btn_pulse.sv - button synchroniser, optional debouncer (STOPWATCH_CTRL_DEBOUNCE_EN), rising-edge pulse
module btn_pulse #(
   parameter int DEB_CYCLES = 16
) (
   input  logic CLK,
   input  logic CLR,
   input  logic raw,
   output logic level,
   output logic press
);

   logic sync_a;
   logic prev;

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          sync_b;
   logic [CW-1:0] deb_cnt;

   // Two-flop synchroniser, then accept a new level only after DEB_CYCLES agreeing samples
   always_ff @(posedge CLK) begin
      if (CLR) begin
         sync_a  <= 1'b0;
         sync_b  <= 1'b0;
         level   <= 1'b0;
         deb_cnt <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         if (sync_b == level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
            level   <= sync_b;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end
`else
   // Two-flop synchroniser; the second flop doubles as the level register
   always_ff @(posedge CLK) begin
      if (CLR) begin
         sync_a <= 1'b0;
         level  <= 1'b0;
      end else begin
         sync_a <= raw;
         level  <= sync_a;
      end
   end
`endif

   // Previous level, so a held button yields a single press
   always_ff @(posedge CLK) begin
      if (CLR) begin
         prev <= 1'b0;
      end else begin
         prev <= level;
      end
   end

   assign press = level & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM, prescaler and tick generation (STOPWATCH_CTRL_DEBOUNCE_EN adds button debouncing)
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int DEB_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       START_STOP,
   input  logic       LAP,
   input  logic       CLEAR_BTN,
   output logic       tick_en,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic       running,
   output logic [1:0] state
);

   localparam int PW = $clog2(TICK_DIV);

   state_t        state_q;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_next;
   logic          at_wrap;
   logic          ss_p;
   logic          lap_p;
   logic          clr_p;
   logic          sel_clr;
   logic          sel_ss;
   logic          sel_lap;

   btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_ss (
      .CLK(CLK), .CLR(CLR), .raw(START_STOP), .level(), .press(ss_p)
   );

   btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
      .CLK(CLK), .CLR(CLR), .raw(LAP), .level(), .press(lap_p)
   );

   btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
      .CLK(CLK), .CLR(CLR), .raw(CLEAR_BTN), .level(), .press(clr_p)
   );

   // Only the highest-priority press of a cycle is offered to the FSM
   assign sel_clr = clr_p;
   assign sel_ss  = ss_p & ~clr_p;
   assign sel_lap = lap_p & ~ss_p & ~clr_p;

   assign at_wrap    = (presc == PW'(TICK_DIV - 1));
   assign presc_next = at_wrap ? '0 : presc + 1'b1;
   assign tick_en    = at_wrap & is_counting(state_q);
   assign state      = state_q;

   // Control FSM with registered outputs and the tick prescaler
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q   <= ST_IDLE;
         presc     <= '0;
         cnt_clr   <= 1'b1;
         disp_hold <= 1'b0;
         running   <= 1'b0;
      end else begin
         cnt_clr <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               presc <= '0;
               if (sel_clr) begin
                  cnt_clr <= 1'b1;
               end else if (sel_ss) begin
                  state_q <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               presc <= presc_next;
               if (sel_ss) begin
                  state_q <= ST_PAUSED;
                  running <= 1'b0;
               end else if (sel_lap) begin
                  state_q   <= ST_LAP_HOLD;
                  disp_hold <= 1'b1;
               end
            end
            ST_LAP_HOLD: begin
               presc <= presc_next;
               if (sel_ss) begin
                  state_q   <= ST_PAUSED;
                  running   <= 1'b0;
                  disp_hold <= 1'b0;
               end else if (sel_lap) begin
                  state_q   <= ST_RUN;
                  disp_hold <= 1'b0;
               end
            end
            ST_PAUSED: begin
               // Prescaler holds so the partial tick survives a pause
               if (sel_clr) begin
                  state_q <= ST_IDLE;
                  presc   <= '0;
                  cnt_clr <= 1'b1;
               end else if (sel_ss) begin
                  state_q <= ST_RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               presc     <= '0;
               disp_hold <= 1'b0;
               running   <= 1'b0;
            end
         endcase
      end
   end

endmodule
